// File: rtl/fetch_ctrl_if.sv
// Instruction-bus request/response bundle between the fetch controller and instruction memory.
interface fetch_ctrl_if #(
  parameter int XLEN = 64
) ();
  logic            ireq_valid;
  logic [XLEN-1:0] ireq_addr;
  logic            iresp_addr_ok;
  logic            iresp_data_ok;
  logic [31:0]     iresp_data;

  modport master (
    output ireq_valid,
    output ireq_addr,
    input  iresp_addr_ok,
    input  iresp_data_ok,
    input  iresp_data
  );

  modport slave (
    input  ireq_valid,
    input  ireq_addr,
    output iresp_addr_ok,
    output iresp_data_ok,
    output iresp_data
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: owns the fetch PC, runs the single-outstanding instruction-bus
// handshake, presents instructions to decode and squashes responses made stale by redirects.
module fetch_ctrl #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_next,
  input  logic            redirect,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic            Iwait,
  fetch_ctrl_if.master    ibus,
  output logic            f_valid,
  output logic [XLEN-1:0] f_pc,
  output logic [31:0]     f_instr
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t          state_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] kill_pc_reg;
  logic            kill_reg;
  logic            f_valid_reg;
  logic [XLEN-1:0] f_pc_reg;
  logic [31:0]     f_instr_reg;

  logic done;
  logic advance;

  // The outstanding fetch retires either in the accept cycle or later from WAIT.
  assign done = ((state_reg == REQ) && ibus.iresp_addr_ok && ibus.iresp_data_ok) ||
                ((state_reg == WAIT) && ibus.iresp_data_ok);

  assign advance = !redirect && !stall &&
                   ((done && !kill_reg) || (state_reg == HOLD));

  assign Iwait           = reset || !advance;
  assign ibus.ireq_valid = !reset && (state_reg == REQ);
  assign ibus.ireq_addr  = pc_reg;

  assign pc      = pc_reg;
  assign f_valid = f_valid_reg;
  assign f_pc    = f_pc_reg;
  assign f_instr = f_instr_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      pc_reg      <= PC_RESET;
      kill_reg    <= 1'b0;
      kill_pc_reg <= '0;
      f_valid_reg <= 1'b0;
      f_pc_reg    <= '0;
      f_instr_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg <= REQ;
          if (redirect) pc_reg <= pc_next;
        end
        REQ, WAIT: begin
          if (done) begin
            state_reg <= REQ;
            kill_reg  <= 1'b0;
            if (redirect) begin
              f_valid_reg <= 1'b0;
              pc_reg      <= pc_next;
            end else if (kill_reg) begin
              f_valid_reg <= 1'b0;
              pc_reg      <= kill_pc_reg;
            end else begin
              f_valid_reg <= 1'b1;
              f_pc_reg    <= pc_reg;
              f_instr_reg <= ibus.iresp_data;
              if (stall) state_reg <= HOLD;
              else       pc_reg    <= pc_next;
            end
          end else begin
            f_valid_reg <= 1'b0;
            if ((state_reg == REQ) && ibus.iresp_addr_ok) state_reg <= WAIT;
            // The bus request keeps its address; only the eventual retire target changes.
            if (redirect) begin
              kill_reg    <= 1'b1;
              kill_pc_reg <= pc_next;
            end
          end
        end
        HOLD: begin
          if (redirect || !stall) begin
            f_valid_reg <= 1'b0;
            pc_reg      <= pc_next;
            state_reg   <= REQ;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed and randomized bench for fetch_ctrl against a fetch-lifecycle reference model.
module tb_fetch_ctrl;
  localparam int          XLEN     = 64;
  localparam logic [63:0] PC_RESET = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic        stall;
  logic [63:0] pc_next;
  logic [63:0] pc;
  logic        Iwait;
  logic        f_valid;
  logic [63:0] f_pc;
  logic [31:0] f_instr;

  int errors = 0;
  int checks = 0;

  // Reference model: where the fetch PC points, whether a fetch is in flight, whether a
  // redirect has doomed it, and what decode should currently be seeing.
  bit          m_idle, m_inflight, m_doomed, m_holding, m_fv;
  logic [63:0] m_pc, m_doom_pc, m_fpc;
  logic [31:0] m_finstr;

  fetch_ctrl_if #(.XLEN(XLEN)) bus ();

  fetch_ctrl #(.XLEN(XLEN), .PC_RESET(PC_RESET)) dut (
    .clk      (clk),
    .reset    (reset),
    .pc_next  (pc_next),
    .redirect (redirect),
    .stall    (stall),
    .pc       (pc),
    .Iwait    (Iwait),
    .ibus     (bus),
    .f_valid  (f_valid),
    .f_pc     (f_pc),
    .f_instr  (f_instr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    redirect          = 1'b0;
    stall             = 1'b0;
    bus.iresp_addr_ok = 1'b0;
    bus.iresp_data_ok = 1'b0;
  endtask

  // One clock: compare outputs mid-cycle, advance the model, return just after the edge.
  task automatic tick();
    bit req_exp, compl, adv;
    @(negedge clk);
    req_exp = !reset && !m_idle && !m_holding && !m_inflight;
    compl   = (req_exp && bus.iresp_addr_ok && bus.iresp_data_ok) ||
              (m_inflight && bus.iresp_data_ok);
    adv     = !reset && !redirect && !stall && ((compl && !m_doomed) || m_holding);
    chk("ireq_valid", 64'(bus.ireq_valid), 64'(req_exp));
    chk("Iwait", 64'(Iwait), 64'(!adv));
    if (!reset) begin
      if (req_exp) chk("ireq_addr", bus.ireq_addr, m_pc);
      chk("pc", pc, m_pc);
      chk("f_valid", 64'(f_valid), 64'(m_fv));
      if (m_fv) begin
        chk("f_pc", f_pc, m_fpc);
        chk("f_instr", 64'(f_instr), 64'(m_finstr));
      end
    end
    if (reset) begin
      m_idle = 1; m_inflight = 0; m_doomed = 0; m_holding = 0; m_fv = 0;
      m_pc = PC_RESET; m_fpc = '0; m_finstr = '0;
    end else if (m_idle) begin
      m_idle = 0;
      if (redirect) m_pc = pc_next;
    end else if (m_holding) begin
      if (redirect || !stall) begin
        m_holding = 0; m_fv = 0; m_pc = pc_next;
      end
    end else if (compl) begin
      m_inflight = 0;
      if (redirect) begin
        m_fv = 0; m_pc = pc_next; m_doomed = 0;
      end else if (m_doomed) begin
        m_fv = 0; m_pc = m_doom_pc; m_doomed = 0;
      end else begin
        m_fv = 1; m_fpc = m_pc; m_finstr = bus.iresp_data;
        if (stall) m_holding = 1;
        else       m_pc = pc_next;
      end
    end else begin
      m_fv = 0;
      if (req_exp && bus.iresp_addr_ok) m_inflight = 1;
      if (redirect) begin
        m_doomed = 1; m_doom_pc = pc_next;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle_in();
    pc_next        = '0;
    bus.iresp_data = '0;
    m_idle = 1; m_inflight = 0; m_doomed = 0; m_holding = 0; m_fv = 0;
    m_pc = PC_RESET; m_doom_pc = '0; m_fpc = '0; m_finstr = '0;
    tick();
    tick();
    chk("rst_pc", pc, PC_RESET);
    chk("rst_f_valid", 64'(f_valid), 64'd0);
    chk("rst_f_pc", f_pc, 64'd0);
    reset = 1'b0;
    tick();

    // Same-cycle accept and data.
    chk("t1_addr", bus.ireq_addr, 64'h8000_0000);
    chk("t1_valid", 64'(bus.ireq_valid), 64'd1);
    bus.iresp_addr_ok = 1'b1; bus.iresp_data_ok = 1'b1;
    bus.iresp_data = 32'h0000_0013; pc_next = 64'h8000_0004;
    #1 chk("t1_iwait", 64'(Iwait), 64'd0);
    tick();
    idle_in();
    chk("t1_f_valid", 64'(f_valid), 64'd1);
    chk("t1_f_pc", f_pc, 64'h8000_0000);
    chk("t1_f_instr", 64'(f_instr), 64'h13);
    chk("t1_pc", pc, 64'h8000_0004);

    // Delayed accept, then WAIT, then data.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_addr", bus.ireq_addr, 64'h8000_0004);
    end
    bus.iresp_addr_ok = 1'b1;
    tick();
    idle_in();
    chk("t2_wait_valid", 64'(bus.ireq_valid), 64'd0);
    tick();
    bus.iresp_data_ok = 1'b1; bus.iresp_data = $urandom; pc_next = 64'h8000_0008;
    tick();
    idle_in();

    // Completion under stall, held for three cycles.
    bus.iresp_addr_ok = 1'b1; bus.iresp_data_ok = 1'b1; stall = 1'b1;
    bus.iresp_data = 32'h1234_5678;
    tick();
    bus.iresp_addr_ok = 1'b0; bus.iresp_data_ok = 1'b0;
    tick();
    tick();
    chk("t3_f_valid", 64'(f_valid), 64'd1);
    chk("t3_f_pc", f_pc, 64'h8000_0008);
    chk("t3_f_instr", 64'(f_instr), 64'h1234_5678);
    chk("t3_pc", pc, 64'h8000_0008);
    stall = 1'b0; pc_next = 64'h8000_000C;
    #1 chk("t3_iwait", 64'(Iwait), 64'd0);
    tick();
    chk("t3_f_valid_drop", 64'(f_valid), 64'd0);
    chk("t3_pc_adv", pc, 64'h8000_000C);

    // Two redirects while waiting; the stale response is dropped.
    bus.iresp_addr_ok = 1'b1;
    tick();
    bus.iresp_addr_ok = 1'b0; redirect = 1'b1; pc_next = 64'h8000_1000;
    tick();
    pc_next = 64'h8000_2000;
    tick();
    redirect = 1'b0; bus.iresp_data_ok = 1'b1; pc_next = 64'h8000_0010;
    tick();
    idle_in();
    chk("t4_f_valid", 64'(f_valid), 64'd0);
    chk("t4_addr", bus.ireq_addr, 64'h8000_2000);

    // Redirect coinciding with data.
    bus.iresp_addr_ok = 1'b1;
    tick();
    bus.iresp_addr_ok = 1'b0; bus.iresp_data_ok = 1'b1;
    redirect = 1'b1; pc_next = 64'h8000_3000;
    tick();
    idle_in();
    chk("t5_f_valid", 64'(f_valid), 64'd0);
    chk("t5_addr", bus.ireq_addr, 64'h8000_3000);

    // Reset while waiting, then stale data_ok in IDLE and in REQ.
    bus.iresp_addr_ok = 1'b1;
    tick();
    idle_in();
    reset = 1'b1;
    tick();
    reset = 1'b0; bus.iresp_data_ok = 1'b1;
    tick();
    tick();
    idle_in();
    chk("t6_pc", pc, PC_RESET);
    chk("t6_addr", bus.ireq_addr, PC_RESET);
    chk("t6_valid", 64'(bus.ireq_valid), 64'd1);
    chk("t6_f_valid", 64'(f_valid), 64'd0);

    // Randomized traffic with a well-behaved memory.
    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(0, 299) == 0);
      redirect = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) stall = ~stall;
      pc_next           = 64'h8000_0000 + 64'($urandom_range(0, 4095)) * 64'd4;
      bus.iresp_addr_ok = 1'($urandom_range(0, 1));
      bus.iresp_data    = $urandom;
      if (m_inflight)
        bus.iresp_data_ok = ($urandom_range(0, 2) == 0);
      else if (!m_idle && !m_holding)
        bus.iresp_data_ok = bus.iresp_addr_ok && ($urandom_range(0, 3) == 0);
      else
        bus.iresp_data_ok = 1'b0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Fetch-stage controller downstream of the next-PC selector.
- Owns the architectural fetch PC register and drives the instruction-bus request handshake (valid/addr_ok/data_ok).
- Presents each fetched instruction with its PC to decode.
- Produces the Iwait and pc signals consumed by the next-PC selector.
- Handles redirects that arrive while a fetch is outstanding by discarding the stale response.

Parameters:
PC_RESET, 64'h0000_0000_8000_0000, fetch PC loaded on reset
XLEN, 64, PC/address width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
pc_next  in  XLEN  next PC from selector, sampled only on advance or redirect
redirect  in  1  resolved branch/jump; pc_next is the target this cycle
stall  in  1  decode cannot accept; hold f_* outputs
pc  out  XLEN  current fetch PC (to selector)
Iwait  out  1  fetch not completing this cycle; selector must hold pc
ireq_valid  out  1  instruction-bus request valid
ireq_addr  out  XLEN  request address
iresp_addr_ok  in  1  request accepted
iresp_data_ok  in  1  instruction data returned
iresp_data  in  32  instruction word
f_valid  out  1  f_pc/f_instr valid to decode
f_pc  out  XLEN  PC of presented instruction
f_instr  out  32  presented instruction

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high: state<=IDLE, pc<=PC_RESET, kill<=0, kill_pc<=0, f_valid<=0, f_pc<=0, f_instr<=0. During the reset cycle and IDLE, ireq_valid=0 and Iwait=1.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - Always goes to REQ the next cycle.
  - redirect in IDLE: pc<=pc_next.
- REQ:
  - Drives ireq_valid=1, ireq_addr=pc.
  - ireq_addr must stay stable until addr_ok.
  - addr_ok=0: stay in REQ.
  - addr_ok=1, data_ok=0: go to WAIT.
  - addr_ok=1 and data_ok=1 in the same cycle: complete immediately.
- WAIT:
  - Drives ireq_valid=0.
  - Waits for data_ok; complete on data_ok.
- Completion (data_ok cycle), when kill=0 and redirect=0:
  - f_valid<=1, f_pc<=pc, f_instr<=iresp_data.
  - If stall=0: pc<=pc_next, Iwait=0 this cycle, next state REQ.
  - If stall=1: go to HOLD, Iwait=1.
- HOLD:
  - f_* outputs stay constant.
  - When stall drops: pc<=pc_next, Iwait=0 that cycle, f_valid<=0, next state REQ.
- f_valid handshake:
  - Outside HOLD, f_valid is high exactly one cycle per delivered instruction.
  - Decode consumes f_* in any cycle where f_valid=1 and stall=0.
- Redirect while a request is outstanding (REQ or WAIT):
  - kill<=1, kill_pc<=pc_next.
  - The latest redirect overwrites kill_pc.
  - The request continues unchanged on the bus.
  - On its data_ok the response is discarded: f_valid<=0, pc<=kill_pc, kill<=0, next state REQ.
- Redirect coinciding with data_ok: response discarded, pc<=pc_next (redirect target wins over kill_pc), next state REQ.
- Redirect in HOLD: f_valid<=0, pc<=pc_next, next state REQ, regardless of stall.
- Iwait:
  - Iwait=0 only in a cycle where the PC advances via pc_next in a non-redirect completion or HOLD release.
  - Iwait=1 in every other cycle.
  - pc changes only in those Iwait=0 cycles, on redirect, or on a killed-response retire.
- Arithmetic: none. The PC is never incremented internally; all increments come from pc_next.
- Reset mid-operation (REQ/WAIT): state, pc and kill flags are abandoned. A data_ok arriving after reset while in IDLE/REQ with no outstanding request is ignored.
- No more than one outstanding request, ever.

Test Plan:
- Reset then addr_ok/data_ok same cycle, data=32'h00000013, pc_next=PC_RESET+4 -> ireq_addr=80000000 cycle 1; next cycle f_valid=1, f_pc=80000000, f_instr=00000013; pc=80000004; Iwait=0 only on the data cycle.
- addr_ok delayed 3 cycles, data_ok 2 cycles later -> ireq_valid high 4 cycles with constant addr; ireq_valid=0 in WAIT; Iwait=1 throughout until data_ok.
- stall=1 for 3 cycles at completion -> f_valid/f_pc/f_instr constant for 4 cycles; pc unchanged; on stall drop pc<=pc_next, f_valid falls next cycle.
- redirect=1 with pc_next=80001000 during WAIT, then redirect with 80002000 before data_ok -> returned instruction never appears (f_valid stays 0); next ireq_addr=80002000.
- redirect with 80003000 in the same cycle as data_ok -> no f_valid; next request address 80003000.
- Assert reset while in WAIT, then spurious data_ok -> outputs at reset values; first request after reset uses PC_RESET; no f_valid from the stale data.
